// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the shadowed PWM engine
// Purpose: FSM state encoding, default counter width and shadow reset values.
// Ports: none (package).
package pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_t;

    localparam int PWM_CNT_W = 16;

    localparam logic [PWM_CNT_W-1:0] HIGH_SH_RST = '0;
    localparam logic [PWM_CNT_W-1:0] FREQ_SH_RST = '0;

endpackage

// File: rtl/pwm_shadow_gen_if.sv
// rtl/pwm_shadow_gen_if.sv - register-file side bundle of the shadowed PWM engine
// Purpose: groups the run request, the configuration words and the status back to the register file.
// Ports (signals):
//   start        run request, level-sensitive
//   cycles_high  requested high time in clk cycles
//   cycles_freq  requested period in clk cycles
//   pwm          PWM output
//   period_done  pulse on the last cycle of each period
//   busy         engine running
//   cfg_err      sticky illegal-configuration flag
// Modports: master = register file, slave = PWM engine.
interface pwm_shadow_gen_if
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
);
    logic             start;
    logic [CNT_W-1:0] cycles_high;
    logic [CNT_W-1:0] cycles_freq;
    logic             pwm;
    logic             period_done;
    logic             busy;
    logic             cfg_err;

    modport master (
        output start, cycles_high, cycles_freq,
        input  pwm, period_done, busy, cfg_err
    );

    modport slave (
        input  start, cycles_high, cycles_freq,
        output pwm, period_done, busy, cfg_err
    );

endinterface

// File: rtl/pwm_sync2.sv
// rtl/pwm_sync2.sv - generic two-flop synchronizer with asynchronous reset
// Purpose: brings an asynchronous level into the clk domain; output resets to 0.
// Ports:
//   clk    destination clock
//   rst_n  asynchronous active-low reset
//   d      asynchronous input level
//   q      synchronized level, two clk cycles behind d
module pwm_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pwm_shadow_gen.sv
// rtl/pwm_shadow_gen.sv - double-buffered PWM engine fed by the register file
// Purpose: latches cycles_high/cycles_freq into shadows only at period boundaries and
//   drives a glitch-free PWM output; reports period completion, busy and bad config.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    pwm_shadow_gen_if.slave (start, cycles_high, cycles_freq in;
//          pwm, period_done, busy, cfg_err out)
// Build option: PWM_SYNC_START_EN puts start through a two-flop synchronizer
//   (start/stop latency +2 cycles); otherwise start must already be synchronous.
module pwm_shadow_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    pwm_shadow_gen_if.slave   bus
);

    pwm_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] high_sh, high_nxt;
    logic [CNT_W-1:0] freq_sh, freq_nxt;
    logic             pwm_q, pwm_nxt;
    logic             pd_q, pd_nxt;
    logic             cfg_q, cfg_nxt;
    logic             start_s;

`ifdef PWM_SYNC_START_EN
    pwm_sync2 u_start_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.start),
        .q     (start_s)
    );
`else
    assign start_s = bus.start;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            high_sh <= CNT_W'(HIGH_SH_RST);
            freq_sh <= CNT_W'(FREQ_SH_RST);
            pwm_q   <= 1'b0;
            pd_q    <= 1'b0;
            cfg_q   <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            high_sh <= high_nxt;
            freq_sh <= freq_nxt;
            pwm_q   <= pwm_nxt;
            pd_q    <= pd_nxt;
            cfg_q   <= cfg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        high_nxt  = high_sh;
        freq_nxt  = freq_sh;
        cfg_nxt   = cfg_q;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start_s) begin
                    if (bus.cycles_freq != '0) begin
                        high_nxt  = bus.cycles_high;
                        freq_nxt  = bus.cycles_freq;
                        state_nxt = RUN;
                    end else begin
                        cfg_nxt = 1'b1;
                    end
                end else begin
                    cfg_nxt = 1'b0;
                end
            end
            RUN: begin
                if (cnt == freq_sh - 1'b1) begin
                    cnt_nxt = '0;
                    if (start_s && (bus.cycles_freq != '0)) begin
                        high_nxt = bus.cycles_high;
                        freq_nxt = bus.cycles_freq;
                    end else begin
                        if (start_s) begin
                            cfg_nxt = 1'b1;
                        end
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs are registered from the next count/shadows so they line up with cnt.
        pwm_nxt = (state_nxt == RUN) && (cnt_nxt < high_nxt);
        pd_nxt  = (state_nxt == RUN) && (cnt_nxt == freq_nxt - 1'b1);
    end

    assign bus.pwm         = pwm_q;
    assign bus.period_done = pd_q;
    assign bus.busy        = (state == RUN);
    assign bus.cfg_err     = cfg_q;

endmodule

// File: tb/tb_pwm_shadow_gen.sv
// tb/tb_pwm_shadow_gen.sv - directed self-checking bench for pwm_shadow_gen
module tb_pwm_shadow_gen;
    import pwm_pkg::*;

`ifdef PWM_SYNC_START_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    pwm_shadow_gen_if #(.CNT_W(16)) bus ();

    pwm_shadow_gen #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic cfg_exp);
        check({tag, "_pwm"}, 32'(bus.pwm), 32'd0);
        check({tag, "_pd"}, 32'(bus.period_done), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_cfg"}, 32'(bus.cfg_err), 32'(cfg_exp));
    endtask

    // Observes n cycles at the falling edge; bit i of each pattern is cycle i.
    task automatic run_cycles(input int n, input string tag, input logic [63:0] pwm_pat,
                              input logic [63:0] pd_pat, input logic busy_exp);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s_pwm%0d", tag, i), 32'(bus.pwm), 32'(pwm_pat[i]));
            check($sformatf("%s_pd%0d", tag, i), 32'(bus.period_done), 32'(pd_pat[i]));
            check($sformatf("%s_busy%0d", tag, i), 32'(bus.busy), 32'(busy_exp));
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.cycles_high = 16'd0;
        bus.cycles_freq = 16'd0;

        // Reset state, then stays quiet with start low.
        @(negedge clk);
        check_idle("rst", 1'b0);
        rst_n = 1'b1;
        run_cycles(3, "post_rst", 64'd0, 64'd0, 1'b0);
        check_idle("post_rst", 1'b0);

        // Basic 3/5.
        bus.cycles_high = 16'd3;
        bus.cycles_freq = 16'd5;
        bus.start       = 1'b1;
        run_cycles(LAT, "basic_lat", 64'd0, 64'd0, 1'b0);
        run_cycles(10, "basic", 64'b00111_00111, 64'b10000_10000, 1'b1);

        // Shadow update at cnt = 2.
        run_cycles(3, "shd_a", 64'b111, 64'b000, 1'b1);
        bus.cycles_high = 16'd1;
        bus.cycles_freq = 16'd4;
        run_cycles(6, "shd_b", 64'b000100, 64'b100010, 1'b1);

        // Graceful stop: reload 3/5, drop start at cnt = 1.
        bus.cycles_high = 16'd3;
        bus.cycles_freq = 16'd5;
        run_cycles(2, "stop_a", 64'b11, 64'b00, 1'b1);
        bus.start = 1'b0;
        run_cycles(3, "stop_b", 64'b001, 64'b100, 1'b1);
        run_cycles(3, "stop_c", 64'd0, 64'd0, 1'b0);

        // freq = 0 -> sticky cfg_err, cleared by start low in IDLE.
        bus.cycles_freq = 16'd0;
        bus.start       = 1'b1;
        repeat (LAT) @(negedge clk);
        @(negedge clk);
        check_idle("cfg_set", 1'b1);
        @(negedge clk);
        check_idle("cfg_hold", 1'b1);
        bus.start = 1'b0;
        repeat (LAT) @(negedge clk);
        @(negedge clk);
        check_idle("cfg_clr", 1'b0);

        // high > freq -> constant high.
        bus.cycles_high = 16'd7;
        bus.cycles_freq = 16'd5;
        bus.start       = 1'b1;
        run_cycles(LAT, "full_lat", 64'd0, 64'd0, 1'b0);
        run_cycles(10, "full", 64'b11111_11111, 64'b10000_10000, 1'b1);

        // high = 0 -> constant low.
        bus.cycles_high = 16'd0;
        run_cycles(5, "zero", 64'b00000, 64'b10000, 1'b1);

        // freq = 1 -> period_done continuously high.
        bus.cycles_high = 16'd1;
        bus.cycles_freq = 16'd1;
        run_cycles(5, "f1", 64'b11111, 64'b11111, 1'b1);

        // Asynchronous reset mid-run.
        #2 rst_n = 1'b0;
        #1 check_idle("arst", 1'b0);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(3, "arst_post", 64'd0, 64'd0, 1'b0);
        check_idle("arst_post", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
